// File: rtl/mask_index_encoder.sv
// mask_index_encoder: serialises a request mask into set-bit indices, lowest first, over valid/ready
module mask_index_encoder #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Load_i,
  input  logic [N-1:0] Mask_i,
  input  logic         Ready_i,
  output logic         Valid_o,
  output logic [W-1:0] Index_o,
  output logic         Busy_o,
  output logic [W:0]   Count_o,
  output logic         Done_o
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state_q, state_d;
  logic [N-1:0] mask_q, mask_d, rest;
  logic [W-1:0] index_q, index_d;
  logic [W:0]   count_q, count_d;
  logic         valid_q, valid_d, done_q, done_d, load, xfer;

  function automatic logic [W-1:0] lowest(input logic [N-1:0] m);
    lowest = '0;
    for (int i = N-1; i >= 0; i--) if (m[i]) lowest = i[W-1:0];
  endfunction

  function automatic logic [W:0] popcount(input logic [N-1:0] m);
    popcount = '0;
    for (int i = 0; i < N; i++) popcount = popcount + (W+1)'(m[i]);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      index_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      index_q <= index_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    rest    = mask_q & ~({{(N-1){1'b0}}, 1'b1} << index_q);
    state_d = (state_q == IDLE) ? ((Load_i && |Mask_i) ? EMIT : IDLE)
                                : ((Ready_i && ~|rest) ? IDLE : EMIT);
  end

  always_comb begin
    load    = (state_q == IDLE) && Load_i;
    xfer    = (state_q == EMIT) && Ready_i;
    mask_d  = load ? Mask_i : xfer ? rest : mask_q;
    index_d = load ? lowest(Mask_i) : xfer ? lowest(rest) : index_q;
    count_d = load ? popcount(Mask_i) : xfer ? count_q - 1'b1 : count_q;
    valid_d = (state_d == EMIT);
    done_d  = (load && ~|Mask_i) || (xfer && ~|rest);
  end

  assign Valid_o = valid_q;
  assign Index_o = index_q;
  assign Busy_o  = (state_q == EMIT);
  assign Count_o = count_q;
  assign Done_o  = done_q;
endmodule

// File: tb/tb_mask_index_encoder.sv
// tb_mask_index_encoder: queue-based reference model plus directed and random valid/ready traffic
module tb_mask_index_encoder;
  localparam int N = 32;
  localparam int W = 5;
  logic clk = 1'b0, reset = 1'b1, Load_i = 1'b0, Ready_i = 1'b0;
  logic [N-1:0] Mask_i = '0;
  logic Valid_o, Busy_o, Done_o;
  logic [W-1:0] Index_o;
  logic [W:0] Count_o;
  int tests = 0, fails = 0, dn = 0;
  bit en = 0, m_busy = 0, m_done = 0;
  int mq[$], got[$], mgot[$];

  always #5 clk = ~clk;

  mask_index_encoder #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .Load_i(Load_i), .Mask_i(Mask_i), .Ready_i(Ready_i),
    .Valid_o(Valid_o), .Index_o(Index_o), .Busy_o(Busy_o), .Count_o(Count_o), .Done_o(Done_o)
  );

  // model: pending indices as an ascending queue; a transfer pops the head
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_busy = 0;
      m_done = 0;
    end else if (m_busy) begin
      m_done = 0;
      if (Ready_i) begin
        mgot.push_back(mq.pop_front());
        if (mq.size() == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end else begin
      m_done = Load_i && (Mask_i == '0);
      if (Load_i && Mask_i != '0) begin
        for (int k = 0; k < N; k++) if (Mask_i[k]) mq.push_back(k);
        m_busy = 1;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (en) begin
    chk("valid", 32'(Valid_o), 32'(m_busy));
    chk("index", 32'(Index_o), m_busy ? mq[0] : 0);
    chk("busy", 32'(Busy_o), 32'(m_busy));
    chk("count", 32'(Count_o), mq.size());
    chk("done", 32'(Done_o), 32'(m_done));
    if (Valid_o && Ready_i) got.push_back(int'(Index_o));
    if (Done_o) dn++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(logic [N-1:0] m);
    Load_i = 1'b1;
    Mask_i = m;
    step();
    Load_i = 1'b0;
    Mask_i = $urandom;
  endtask

  task automatic drain();
    int b = 0;
    while (Busy_o && b < 200) begin
      step();
      b++;
    end
    if (b >= 200) chk("drain_timeout", 32'(Busy_o), 0);
    step();
  endtask

  task automatic clr();
    got.delete();
    mgot.delete();
    dn = 0;
  endtask

  task automatic chk_seq(string nm, int a[$], int e[$]);
    chk({nm, "_len"}, a.size(), e.size());
    for (int i = 0; i < e.size() && i < a.size(); i++) chk(nm, a[i], e[i]);
  endtask

  initial begin
    int dc, r;
    int e[$];
    repeat (2) @(posedge clk);
    #1;
    en = 1;
    chk("rst_valid", 32'(Valid_o), 0);
    chk("rst_count", 32'(Count_o), 0);
    chk("rst_done", 32'(Done_o), 0);
    reset = 1'b0;
    step();
    // 1: 0x13 with Ready held high
    clr();
    Ready_i = 1'b1;
    load(32'h0000_0013);
    chk("s1_count0", 32'(Count_o), 3);
    dc = 0;
    while (!Done_o && dc < 20) begin
      step();
      dc++;
    end
    chk("s1_done_lat", dc, 3);
    step();
    e = {0, 1, 4};
    chk_seq("s1_dut", got, e);
    chk_seq("s1_model", mgot, e);
    chk("s1_dn", dn, 1);
    // 2: 0x80000001 with Ready stalls
    clr();
    Ready_i = 1'b0;
    load(32'h8000_0001);
    repeat (3) step();
    chk("s2_hold0", 32'(Index_o), 0);
    Ready_i = 1'b1;
    step();
    chk("s2_idx31", 32'(Index_o), 31);
    Ready_i = 1'b0;
    repeat (2) step();
    chk("s2_hold31", 32'(Index_o), 31);
    Ready_i = 1'b1;
    step();
    chk("s2_valid_drop", 32'(Valid_o), 0);
    chk("s2_done", 32'(Done_o), 1);
    step();
    chk("s2_done_once", 32'(Done_o), 0);
    e = {0, 31};
    chk_seq("s2_dut", got, e);
    chk("s2_dn", dn, 1);
    // 3: full mask
    clr();
    load('1);
    chk("s3_count32", 32'(Count_o), 32);
    drain();
    e.delete();
    for (int i = 0; i < N; i++) e.push_back(i);
    chk_seq("s3_dut", got, e);
    chk_seq("s3_model", mgot, e);
    chk("s3_dn", dn, 1);
    // 4: empty mask
    clr();
    load('0);
    chk("s4_done", 32'(Done_o), 1);
    chk("s4_valid", 32'(Valid_o), 0);
    chk("s4_busy", 32'(Busy_o), 0);
    step();
    chk("s4_done_once", 32'(Done_o), 0);
    chk("s4_none", got.size(), 0);
    // 5: load while busy is dropped, reload afterwards works
    clr();
    load(32'h0000_00F0);
    step();
    load(32'h0000_0001);
    drain();
    e = {4, 5, 6, 7};
    chk_seq("s5_dut", got, e);
    clr();
    load(32'h0000_0001);
    chk("s5_reload", 32'(Index_o), 0);
    chk("s5_reload_v", 32'(Valid_o), 1);
    drain();
    // 6: reset mid-emit
    clr();
    Ready_i = 1'b0;
    load(32'h0000_0F00);
    chk("s6_first", 32'(Index_o), 8);
    Ready_i = 1'b1;
    step();
    Ready_i = 1'b0;
    reset = 1'b1;
    #1;
    chk("s6_rst_valid", 32'(Valid_o), 0);
    chk("s6_rst_count", 32'(Count_o), 0);
    chk("s6_rst_index", 32'(Index_o), 0);
    chk("s6_rst_busy", 32'(Busy_o), 0);
    step();
    reset = 1'b0;
    step();
    chk("s6_no_done", dn, 0);
    load(32'h0000_0004);
    chk("s6_idx2", 32'(Index_o), 2);
    Ready_i = 1'b1;
    drain();
    e = {8, 2};
    chk_seq("s6_dut", got, e);
    // random traffic, including loads while busy and occasional resets
    clr();
    repeat (400) begin
      Ready_i = ($urandom_range(0, 3) != 0);
      Load_i = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 4);
      Mask_i = (r == 0) ? '0 : (r == 1) ? (32'h1 << $urandom_range(0, 31)) :
               (r == 2) ? $urandom : (r == 3) ? ($urandom & $urandom & $urandom) :
               ($urandom_range(0, 1) ? '1 : 32'h8000_0000);
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    Load_i = 1'b0;
    Ready_i = 1'b1;
    step();
    drain();
    chk("rnd_idle", 32'(Busy_o), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
